iob_diff_lag: RTL

Parametrised, streaming first-difference unit: on every accepted sample it outputs `x[n] - x[n-L]`, with the lag L selectable at runtime up to `MAX_LAG`. It adds several features:
- valid handshake;
- signed/unsigned arithmetic;
- optional saturation;
- overflow flag;
- priming indication for the first samples after reset.

It sits in the arith_logic library between a sample source (ADC/sensor front end, counter snapshot) and downstream rate/edge detection logic.

---
 rtl/iob_diff_lag.sv | 122 ++++++++++++
 1 files changed

// File: rtl/iob_diff_lag.sv
// rtl/iob_diff_lag.sv - streaming lagged first-difference unit x[n] - x[n-L]
//
// Ports:
//   clk_i, cke_i, rst_i : clock, clock enable, synchronous active-high reset
//   lag_i               : requested lag (0 -> 1, above MAX_LAG -> MAX_LAG)
//   valid_i, data_i     : input sample strobe and value
//   valid_o, data_o     : registered difference strobe and value
//   ovf_o               : true difference not representable in DATA_W
//   primed_o            : reference sample was a real sample, not RST_VAL

module iob_diff_lag #(
    parameter int                DATA_W  = 32,
    parameter int                MAX_LAG = 4,
    parameter int                LAG_W   = $clog2(MAX_LAG + 1),
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                SIGNED  = 1,
    parameter int                SAT     = 0
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic [LAG_W-1:0]  lag_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              ovf_o,
    output logic              primed_o
);

    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] hist [MAX_LAG];
    logic [LAG_W-1:0]  cnt;

    logic              accept;
    logic [LAG_W-1:0]  lag_eff;
    logic [DATA_W-1:0] ref_val;
    logic [DATA_W:0]   x_ext;
    logic [DATA_W:0]   r_ext;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] res;
    logic              res_ovf;
    logic              res_primed;

    assign accept = valid_i & cke_i;

    always_comb begin
        lag_eff = lag_i;
        if (lag_i == '0) begin
            lag_eff = LAG_W'(1);
        end else if (lag_i > LAG_W'(MAX_LAG)) begin
            lag_eff = LAG_W'(MAX_LAG);
        end
    end

    // Reference is taken from the history before this accept shifts it.
    always_comb begin
        ref_val = hist[0];
        for (int k = 1; k < MAX_LAG; k++) begin
            if (lag_eff == LAG_W'(k + 1)) begin
                ref_val = hist[k];
            end
        end
    end

    // One extra bit makes the subtraction exact for both signednesses.
    assign x_ext = (SIGNED != 0) ? {data_i[DATA_W-1], data_i}   : {1'b0, data_i};
    assign r_ext = (SIGNED != 0) ? {ref_val[DATA_W-1], ref_val} : {1'b0, ref_val};
    assign diff  = x_ext - r_ext;

    always_comb begin
        res     = diff[DATA_W-1:0];
        res_ovf = 1'b0;
        if (SIGNED != 0) begin
            // Exact result leaves the DATA_W range iff the two top bits differ.
            res_ovf = diff[DATA_W] ^ diff[DATA_W-1];
            if (res_ovf && (SAT != 0)) begin
                res = diff[DATA_W] ? S_MIN : S_MAX;
            end
        end else begin
            // Top bit of the unsigned difference is the borrow.
            res_ovf = diff[DATA_W];
            if (res_ovf && (SAT != 0)) begin
                res = '0;
            end
        end
    end

    // cnt counts accepts before this one, so the reference is real once
    // at least lag_eff samples have entered the history.
    assign res_primed = (cnt >= lag_eff);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < MAX_LAG; k++) begin
                hist[k] <= RST_VAL;
            end
            cnt      <= '0;
            valid_o  <= 1'b0;
            data_o   <= '0;
            ovf_o    <= 1'b0;
            primed_o <= 1'b0;
        end else if (cke_i) begin
            valid_o <= accept;
            if (accept) begin
                hist[0] <= data_i;
                for (int k = 1; k < MAX_LAG; k++) begin
                    hist[k] <= hist[k-1];
                end
                if (cnt < LAG_W'(MAX_LAG)) begin
                    cnt <= cnt + LAG_W'(1);
                end
                data_o   <= res;
                ovf_o    <= res_ovf;
                primed_o <= res_primed;
            end
        end
    end

endmodule
